// File: rtl/bus_arbiter_pkg.sv
// Shared serial-bus definitions: arbiter state encoding, master IDs and the
// default slave-select width used by the master and slave ports.
package bus_arbiter_pkg;

  localparam int SLAVE_LEN_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RX_SEL = 2'd1,
    OWNED  = 2'd2
  } state_t;

  localparam logic MASTER_1 = 1'b0;
  localparam logic MASTER_2 = 1'b1;

endpackage

// File: rtl/bus_arbiter_sel_deserializer.sv
// MSB-first serial-to-parallel select receiver: start clears the bit counter,
// each shift consumes one bit, done flags the cycle carrying the last bit.
module bus_arbiter_sel_deserializer #(
  parameter int LEN = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_shift,
  input  logic           i_bit,
  output logic [LEN-1:0] o_sel,
  output logic           o_done
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_done = i_shift && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_shift) begin
      r_cnt <= o_done ? '0 : r_cnt + 1'b1;
    end
  end

  // o_sel already includes the bit on the line, so the full word is usable
  // in the same cycle as o_done.
  if (LEN > 1) begin : g_multi
    logic [LEN-2:0] r_shift;
    always_ff @(posedge clk) begin
      if (i_shift) begin
        r_shift <= o_sel[LEN-2:0];
      end
    end
    assign o_sel = {r_shift, i_bit};
  end else begin : g_single
    assign o_sel = i_bit;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master fixed-priority bus arbiter with serial slave-select reception
// and single-slot split-transaction parking/resume.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int SLAVE_LEN  = SLAVE_LEN_DEF,
  parameter int NUM_SLAVES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m1_request,
  input  logic                  m2_request,
  input  logic                  m1_slave_sel,
  input  logic                  m2_slave_sel,
  input  logic                  m1_trans_done,
  input  logic                  m2_trans_done,
  input  logic [NUM_SLAVES-1:0] split_en,
  output logic                  m1_grant,
  output logic                  m2_grant,
  output logic                  bus_busy,
  output logic                  arbitor_busy,
  output logic [SLAVE_LEN-1:0]  slave_sel,
  output logic                  master_sel,
  output logic                  sel_valid,
  output logic                  sel_error
);

  localparam logic [SLAVE_LEN:0] NUM_SLAVES_W = (SLAVE_LEN + 1)'(NUM_SLAVES);

  state_t               r_state, w_state_nxt;
  logic                 r_m1_grant, w_m1_grant_nxt;
  logic                 r_m2_grant, w_m2_grant_nxt;
  logic                 r_bus_busy, r_arb_busy;
  logic [SLAVE_LEN-1:0] r_slave_sel, w_slave_sel_nxt;
  logic                 r_master_sel, w_master_sel_nxt;
  logic                 r_sel_valid, w_sel_valid_nxt;
  logic                 r_sel_error, w_sel_error_nxt;
  logic                 r_park_vld, w_park_vld_nxt;
  logic                 r_park_master, w_park_master_nxt;
  logic [SLAVE_LEN-1:0] r_park_slave, w_park_slave_nxt;
  logic                 r_park_rel;
  logic                 w_to_idle;

  logic                  w_m1_ok, w_m2_ok, w_resume;
  logic                  w_owner_req, w_owner_done, w_owner_bit;
  logic [NUM_SLAVES-1:0] w_split_cur, w_split_park;
  logic                  w_ds_start, w_ds_shift, w_ds_done;
  logic [SLAVE_LEN-1:0]  w_ds_sel;

  function automatic logic sel_legal(input logic [SLAVE_LEN-1:0] sel,
                                     input logic park_vld,
                                     input logic [SLAVE_LEN-1:0] park_slave);
    return ({1'b0, sel} < NUM_SLAVES_W) && !(park_vld && (sel == park_slave));
  endfunction

  bus_arbiter_sel_deserializer #(.LEN(SLAVE_LEN)) u_sel_deser (
    .clk     (clk),
    .rst_n   (reset),
    .i_start (w_ds_start),
    .i_shift (w_ds_shift),
    .i_bit   (w_owner_bit),
    .o_sel   (w_ds_sel),
    .o_done  (w_ds_done)
  );

  assign w_m1_ok      = m1_request && !(r_park_vld && (r_park_master == MASTER_1));
  assign w_m2_ok      = m2_request && !(r_park_vld && (r_park_master == MASTER_2));
  assign w_owner_req  = r_master_sel ? m2_request    : m1_request;
  assign w_owner_done = r_master_sel ? m2_trans_done : m1_trans_done;
  assign w_owner_bit  = r_master_sel ? m2_slave_sel  : m1_slave_sel;
  assign w_split_cur  = split_en >> r_slave_sel;
  assign w_split_park = split_en >> r_park_slave;
  // Release is registered, so a resume starts one edge after split_en is seen low.
  assign w_resume     = r_park_vld && r_park_rel;

  always_comb begin
    w_state_nxt       = r_state;
    w_m1_grant_nxt    = r_m1_grant;
    w_m2_grant_nxt    = r_m2_grant;
    w_slave_sel_nxt   = r_slave_sel;
    w_master_sel_nxt  = r_master_sel;
    w_sel_valid_nxt   = r_sel_valid;
    w_sel_error_nxt   = 1'b0;
    w_park_vld_nxt    = r_park_vld;
    w_park_master_nxt = r_park_master;
    w_park_slave_nxt  = r_park_slave;
    w_ds_start        = 1'b0;
    w_ds_shift        = 1'b0;
    w_to_idle         = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_resume) begin
          w_state_nxt      = OWNED;
          w_m1_grant_nxt   = (r_park_master == MASTER_1);
          w_m2_grant_nxt   = (r_park_master == MASTER_2);
          w_master_sel_nxt = r_park_master;
          w_slave_sel_nxt  = r_park_slave;
          w_sel_valid_nxt  = 1'b1;
          w_park_vld_nxt   = 1'b0;
        end else if (w_m1_ok || w_m2_ok) begin
          w_state_nxt      = RX_SEL;
          w_m1_grant_nxt   = w_m1_ok;
          w_m2_grant_nxt   = !w_m1_ok;
          w_master_sel_nxt = w_m1_ok ? MASTER_1 : MASTER_2;
          w_slave_sel_nxt  = '0;
          w_ds_start       = 1'b1;
        end
      end
      RX_SEL: begin
        if (!w_owner_req) begin
          w_to_idle = 1'b1;
        end else begin
          w_ds_shift = 1'b1;
          if (w_ds_done) begin
            if (sel_legal(w_ds_sel, r_park_vld, r_park_slave)) begin
              w_state_nxt     = OWNED;
              w_slave_sel_nxt = w_ds_sel;
              w_sel_valid_nxt = 1'b1;
            end else begin
              w_to_idle       = 1'b1;
              w_sel_error_nxt = 1'b1;
            end
          end
        end
      end
      OWNED: begin
        // Completion takes precedence over a same-cycle split request.
        if (w_owner_done) begin
          w_to_idle = 1'b1;
        end else if (w_split_cur[0] && !r_park_vld) begin
          w_to_idle         = 1'b1;
          w_park_vld_nxt    = 1'b1;
          w_park_master_nxt = r_master_sel;
          w_park_slave_nxt  = r_slave_sel;
        end
      end
      default: w_to_idle = 1'b1;
    endcase

    if (w_to_idle) begin
      w_state_nxt      = IDLE;
      w_m1_grant_nxt   = 1'b0;
      w_m2_grant_nxt   = 1'b0;
      w_slave_sel_nxt  = '0;
      w_master_sel_nxt = MASTER_1;
      w_sel_valid_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_m1_grant    <= 1'b0;
      r_m2_grant    <= 1'b0;
      r_bus_busy    <= 1'b0;
      r_arb_busy    <= 1'b0;
      r_slave_sel   <= '0;
      r_master_sel  <= 1'b0;
      r_sel_valid   <= 1'b0;
      r_sel_error   <= 1'b0;
      r_park_vld    <= 1'b0;
      r_park_master <= 1'b0;
      r_park_slave  <= '0;
      r_park_rel    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_m1_grant    <= w_m1_grant_nxt;
      r_m2_grant    <= w_m2_grant_nxt;
      r_bus_busy    <= (w_state_nxt != IDLE);
      r_arb_busy    <= (w_state_nxt == RX_SEL);
      r_slave_sel   <= w_slave_sel_nxt;
      r_master_sel  <= w_master_sel_nxt;
      r_sel_valid   <= w_sel_valid_nxt;
      r_sel_error   <= w_sel_error_nxt;
      r_park_vld    <= w_park_vld_nxt;
      r_park_master <= w_park_master_nxt;
      r_park_slave  <= w_park_slave_nxt;
      r_park_rel    <= r_park_vld && !w_split_park[0];
    end
  end

  assign m1_grant     = r_m1_grant;
  assign m2_grant     = r_m2_grant;
  assign bus_busy     = r_bus_busy;
  assign arbitor_busy = r_arb_busy;
  assign slave_sel    = r_slave_sel;
  assign master_sel   = r_master_sel;
  assign sel_valid    = r_sel_valid;
  assign sel_error    = r_sel_error;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: each step queues the expected registered
// outputs, then compares them after the clock edge.
module tb_bus_arbiter;

  localparam int SLAVE_LEN  = 2;
  localparam int NUM_SLAVES = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  m1_request, m2_request;
  logic                  m1_slave_sel, m2_slave_sel;
  logic                  m1_trans_done, m2_trans_done;
  logic [NUM_SLAVES-1:0] split_en;
  logic                  m1_grant, m2_grant, bus_busy, arbitor_busy;
  logic [SLAVE_LEN-1:0]  slave_sel;
  logic                  master_sel, sel_valid, sel_error;

  bus_arbiter #(.SLAVE_LEN(SLAVE_LEN), .NUM_SLAVES(NUM_SLAVES)) dut (
    .clk           (clk),
    .reset         (reset),
    .m1_request    (m1_request),
    .m2_request    (m2_request),
    .m1_slave_sel  (m1_slave_sel),
    .m2_slave_sel  (m2_slave_sel),
    .m1_trans_done (m1_trans_done),
    .m2_trans_done (m2_trans_done),
    .split_en      (split_en),
    .m1_grant      (m1_grant),
    .m2_grant      (m2_grant),
    .bus_busy      (bus_busy),
    .arbitor_busy  (arbitor_busy),
    .slave_sel     (slave_sel),
    .master_sel    (master_sel),
    .sel_valid     (sel_valid),
    .sel_error     (sel_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [8:0] w_obs;
  assign w_obs = {m1_grant, m2_grant, bus_busy, arbitor_busy, slave_sel,
                  master_sel, sel_valid, sel_error};

  // Packs {m1_grant, m2_grant, bus_busy, arbitor_busy, slave_sel, master_sel, sel_valid, sel_error}.
  function automatic logic [8:0] ev(input bit g1, input bit g2, input bit bb, input bit ab,
                                    input logic [1:0] ss, input bit ms, input bit sv,
                                    input bit se);
    return {g1, g2, bb, ab, ss, ms, sv, se};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed g1g2 bb ab ss ms sv se = %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [8:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    x = sb.pop_front();
    check(x.tag, w_obs, x.exp);
  endtask

  task automatic cyc(input string tag, input logic [8:0] e);
    push_exp(tag, e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic expect_now(input string tag, input logic [8:0] e);
    push_exp(tag, e);
    pop_check();
  endtask

  task automatic idle_inputs();
    m1_request = 0; m2_request = 0; m1_slave_sel = 0; m2_slave_sel = 0;
    m1_trans_done = 0; m2_trans_done = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0;
    split_en = '0;
    idle_inputs();
    #3;
    expect_now("reset_state", ev(0,0,0,0,2'd0,0,0,0));
    @(negedge clk);
    reset = 1;

    // m1 selects slave 2, then completes
    m1_request = 1;
    cyc("t1_grant",  ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 1;
    cyc("t1_bit0",   ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 0;
    cyc("t1_valid",  ev(1,0,1,0,2'd2,0,1,0));
    cyc("t1_hold",   ev(1,0,1,0,2'd2,0,1,0));
    m1_trans_done = 1; m1_request = 0;
    cyc("t1_done",   ev(0,0,0,0,2'd0,0,0,0));
    m1_trans_done = 0;
    cyc("t1_idle",   ev(0,0,0,0,2'd0,0,0,0));

    // simultaneous requests: m1 first, then m2 selects slave 1
    m1_request = 1; m2_request = 1;
    cyc("t2_g1",     ev(1,0,1,1,2'd0,0,0,0));
    cyc("t2_b0",     ev(1,0,1,1,2'd0,0,0,0));
    cyc("t2_own1",   ev(1,0,1,0,2'd0,0,1,0));
    m1_trans_done = 1; m1_request = 0;
    cyc("t2_done1",  ev(0,0,0,0,2'd0,0,0,0));
    m1_trans_done = 0;
    cyc("t2_g2",     ev(0,1,1,1,2'd0,1,0,0));
    m2_slave_sel = 0;
    cyc("t2_b0_m2",  ev(0,1,1,1,2'd0,1,0,0));
    m2_slave_sel = 1;
    cyc("t2_own2",   ev(0,1,1,0,2'd1,1,1,0));
    m2_trans_done = 1; m2_request = 0; m2_slave_sel = 0;
    cyc("t2_done2",  ev(0,0,0,0,2'd0,0,0,0));
    m2_trans_done = 0;

    // split: m1 parks on slave 2, m2 uses the bus, m1 resumes
    m1_request = 1;
    cyc("t3_g1",     ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 1;
    cyc("t3_b0",     ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 0;
    cyc("t3_own",    ev(1,0,1,0,2'd2,0,1,0));
    split_en = 3'b100; m2_request = 1;
    cyc("t3_split",  ev(0,0,0,0,2'd0,0,0,0));
    cyc("t3_g2",     ev(0,1,1,1,2'd0,1,0,0));
    m2_slave_sel = 1;
    cyc("t3_b0_m2",  ev(0,1,1,1,2'd0,1,0,0));
    m2_slave_sel = 0;
    cyc("t3_parked_sel_err", ev(0,0,0,0,2'd0,0,0,1));
    cyc("t3_g2_again", ev(0,1,1,1,2'd0,1,0,0));
    m2_slave_sel = 0;
    cyc("t3_b0_m2b", ev(0,1,1,1,2'd0,1,0,0));
    m2_slave_sel = 1;
    cyc("t3_own2",   ev(0,1,1,0,2'd1,1,1,0));
    m2_trans_done = 1; m2_request = 0; m2_slave_sel = 0;
    cyc("t3_done2",  ev(0,0,0,0,2'd0,0,0,0));
    m2_trans_done = 0;
    cyc("t3_still_parked", ev(0,0,0,0,2'd0,0,0,0));
    split_en = 3'b000;
    cyc("t3_rel_seen", ev(0,0,0,0,2'd0,0,0,0));
    cyc("t3_resume", ev(1,0,1,0,2'd2,0,1,0));
    cyc("t3_resume_hold", ev(1,0,1,0,2'd2,0,1,0));
    m1_trans_done = 1; m1_request = 0;
    cyc("t3_done1",  ev(0,0,0,0,2'd0,0,0,0));
    m1_trans_done = 0;

    // illegal select 11
    m1_request = 1;
    cyc("t4_grant",  ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 1;
    cyc("t4_b0",     ev(1,0,1,1,2'd0,0,0,0));
    cyc("t4_error",  ev(0,0,0,0,2'd0,0,0,1));
    m1_request = 0; m1_slave_sel = 0;
    cyc("t4_pulse_end", ev(0,0,0,0,2'd0,0,0,0));

    // request dropped during select reception
    m1_request = 1;
    cyc("t4_abort_g", ev(1,0,1,1,2'd0,0,0,0));
    m1_request = 0;
    cyc("t4_abort",  ev(0,0,0,0,2'd0,0,0,0));

    // trans_done and split_en together: done wins, nothing parked
    m1_request = 1;
    cyc("t5_grant",  ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 1;
    cyc("t5_b0",     ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 0;
    cyc("t5_own",    ev(1,0,1,0,2'd2,0,1,0));
    m1_trans_done = 1; split_en = 3'b100; m1_request = 0;
    cyc("t5_done_split", ev(0,0,0,0,2'd0,0,0,0));
    m1_trans_done = 0; m1_request = 1;
    cyc("t5_regrant", ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 0;
    cyc("t5_b0b",    ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 1;
    cyc("t5_own1",   ev(1,0,1,0,2'd1,0,1,0));
    m1_trans_done = 1; m1_request = 0; m1_slave_sel = 0;
    cyc("t5_done",   ev(0,0,0,0,2'd0,0,0,0));
    m1_trans_done = 0; split_en = 3'b000;

    // async reset during RX_SEL and during OWNED
    m1_request = 1;
    cyc("t6_grant",  ev(1,0,1,1,2'd0,0,0,0));
    reset = 0;
    #1;
    expect_now("t6_rst_rx", ev(0,0,0,0,2'd0,0,0,0));
    idle_inputs();
    @(negedge clk);
    reset = 1;
    m1_request = 1;
    cyc("t6_grant2", ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 1;
    cyc("t6_b0",     ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 0;
    cyc("t6_own",    ev(1,0,1,0,2'd2,0,1,0));
    reset = 0;
    #1;
    expect_now("t6_rst_own", ev(0,0,0,0,2'd0,0,0,0));
    @(negedge clk);
    reset = 1;
    cyc("t6_fresh_grant", ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 0;
    cyc("t6_fresh_b0", ev(1,0,1,1,2'd0,0,0,0));
    m1_slave_sel = 1;
    cyc("t6_fresh_own", ev(1,0,1,0,2'd1,0,1,0));
    m1_trans_done = 1; m1_request = 0; m1_slave_sel = 0;
    cyc("t6_done",   ev(0,0,0,0,2'd0,0,0,0));
    m1_trans_done = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master bus arbiter with split-transaction support, shared by all master ports on the serial system bus. It is the responder to each master port's approval handshake: it accepts `approval_request`, issues `approval_grant`, drives `bus_busy`/`arbitor_busy`, deserialises the master's slave-select bits and drives the bus mux select. It parks a master whose slave raises `split_en` and resumes that master when the slave releases it.

## Interface
Parameters:
- SLAVE_LEN, 2, width of a slave select; sent serially, MSB first
- NUM_SLAVES, 3, number of valid slave IDs (0..NUM_SLAVES-1)

Ports:
- clk  in  1  bus clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- m1_request, m2_request  in  1  level approval_request from master 1/2; master 1 has fixed priority
- m1_slave_sel, m2_slave_sel  in  1  serial tx_slave_select from master 1/2
- m1_trans_done, m2_trans_done  in  1  one-cycle end-of-transaction pulse from master 1/2
- split_en  in  NUM_SLAVES  per-slave split request, level
- m1_grant, m2_grant  out  1  approval_grant to master 1/2; at most one is high
- bus_busy  out  1  bus owned, or select being received
- arbitor_busy  out  1  arbitration or select reception in progress
- slave_sel  out  SLAVE_LEN  registered select driving the slave/data muxes
- master_sel  out  1  mux owner: 0 = master 1, 1 = master 2
- sel_valid  out  1  slave_sel and master_sel are valid and the owner holds the bus
- sel_error  out  1  one-cycle pulse when a received select is ≥ NUM_SLAVES

## Operation
- FSM states: IDLE, RX_SEL, OWNED.
- IDLE:
  - A request from a non-parked master wins. Master 1 wins over master 2.
  - A parked master whose slave has dropped `split_en` wins over both.
  - New winner -> RX_SEL; its grant is set and the bit counter is cleared.
  - Resumed split master -> OWNED directly; the stored slave is restored.
- RX_SEL:
  - Shift the winner's slave_sel line into the select register, one bit per cycle, SLAVE_LEN bits.
  - After the last bit: value < NUM_SLAVES -> OWNED. Otherwise pulse sel_error, drop the grant and go to IDLE.
  - If the winner drops its request: abort to IDLE, drop the grant, no error pulse.
- OWNED: sel_valid = 1.
  - Owner's trans_done -> IDLE; the grant drops.
  - split_en[slave_sel] = 1 -> record the parked master and slave, drop the grant, go to IDLE.
  - A parked master's request is ignored until its slave drops split_en.
  - Only one parked master at a time. While a master is parked, the other master may own the bus but may not select the parked slave: that select is treated as sel_error.
- Simultaneous trans_done and split_en in OWNED: trans_done wins and nothing is parked.
- Outputs per state:
  - IDLE: bus_busy = 0, arbitor_busy = 0.
  - RX_SEL: bus_busy = 1, arbitor_busy = 1.
  - OWNED: bus_busy = 1, arbitor_busy = 0.
- All outputs are registered.

## Timing
- Reset (asynchronous, while reset = 0):
  - All outputs are 0, FSM is IDLE, parked record is cleared.
  - Reset asserted mid-transaction abandons the transaction with no pulse.
- Request sampled high at edge E0 -> grant and bus_busy high after E0.
- The master drives the select MSB in the cycle after the grant. The arbiter samples bit k at edge E(k+1), k = 0..SLAVE_LEN-1.
- sel_valid is high after edge E(SLAVE_LEN). Request-to-sel_valid latency is 1+SLAVE_LEN cycles (3 at default).
- trans_done sampled at edge T -> grant, sel_valid and bus_busy are low after T. A new grant can follow after T+1.
- split_en sampled at edge S -> the owner's grant is low after S.
- Resume: the parked slave's split_en is sampled low at an edge -> grant and sel_valid are high after the next edge. No select reception on resume.
- sel_error is high for exactly one cycle, coincident with the grant dropping.

## Structure
- Shared bus package holds:
  - state encodings (IDLE = 0, RX_SEL = 1, OWNED = 2)
  - master ID constants
  - the SLAVE_LEN default, shared with master_port/slave_port
- Sub-module sel_deserializer: SLAVE_LEN shift register plus bit counter, with start/shift/done. It is reusable in slave-side address decoding.

## Test plan
- m1_request held, select bits 1,0 -> m1_grant after 1 cycle; slave_sel = 2, sel_valid after 3 cycles; m1_trans_done -> all outputs 0 next cycle.
- Both requests at the same edge -> m1_grant only. After m1_trans_done -> m2_grant next cycle, m2 select 01 -> slave_sel = 1.
- m1 owns slave 2, split_en[2] = 1:
  - m1_grant drops and m2 is granted; m2 selecting slave 1 completes.
  - split_en[2] = 0 -> m1_grant plus sel_valid with slave_sel = 2, master_sel = 0, no select cycles.
- Select 11 with NUM_SLAVES = 3 -> sel_error 1-cycle pulse, grant dropped, back to IDLE.
- trans_done and split_en[slave_sel] in the same cycle -> IDLE, nothing parked; the next m1 request gets a normal grant.
- reset low while in RX_SEL and again while in OWNED -> all outputs 0 immediately; after release, a fresh request is granted normally.
